// File: rtl/uart_rx.sv
// uart_rx - UART receive engine.
//   Samples the asynchronous serial line rxd (2-FF synchronised) using the
//   rx_tick strobe (OVERSAMPLE x baud). Each data bit is sampled at mid-bit,
//   LSB first. Optional parity and the stop bit are checked. Each finished
//   word is offered on a valid/ready interface.
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   rx_tick          single-clk strobe at OVERSAMPLE x baud
//   rxd              serial input, idles high
//   rx_data          received word (valid while rx_valid)
//   rx_valid/ready   handshake; the word is accepted when both are high
//   frame_err        stop bit sampled 0 (qualified by rx_valid)
//   parity_err       parity mismatch (qualified by rx_valid)
//   overrun_err      1-clk pulse: a frame finished while the last word was unaccepted
//   busy             receiver is not idle
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic                 rxd_m, rxd_s;
  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_err_r;
  logic                 bit_tick;
  logic                 frame_done;

  // Synchroniser idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // After the start bit is centred, every later sample is a full bit period
  // (OVERSAMPLE ticks) on, so data, parity and stop all share TICK_END.
  always_comb begin
    bit_tick   = rx_tick && (tick_cnt == TICK_END);
    frame_done = (state == S_STOP) && bit_tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_err_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            state    <= S_START;
            tick_cnt <= '0;
          end
        end
        S_START: begin
          if (rx_tick) begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              if (!rxd_s) begin
                state     <= S_DATA;
                bit_cnt   <= '0;
                par_err_r <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            tick_cnt  <= '0;
            if (bit_cnt == LAST_BIT)
              state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else if (rx_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            par_err_r <= (^shift_reg) ^ rxd_s ^ (PARITY_ODD != 0);
            tick_cnt  <= '0;
            state     <= S_STOP;
          end else if (rx_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            tick_cnt <= '0;
            state    <= rxd_s ? S_IDLE : S_BREAK;
          end else if (rx_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rxd_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output register. A completing frame while the consumer accepts the old
  // word in the same clk is loaded directly (no overrun, rx_valid stays 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (frame_done) begin
        if (rx_valid && !rx_ready) begin
          overrun_err <= 1'b1;
        end else begin
          rx_data    <= shift_reg;
          frame_err  <= !rxd_s;
          parity_err <= par_err_r;
          rx_valid   <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule
